// File: rtl/knn_distance_calc.sv
// Squared-Euclidean distance stage feeding the KNN k-sorter: one query vector is
// held locally and training vectors stream in one feature per cycle.
module knn_distance_calc #(
  parameter int FEAT_WIDTH = 16,
  parameter int DIMENSIONS = 32,
  parameter int VAL_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [31:0]                   num_vectors,
  input  logic                          q_wr_en,
  input  logic [$clog2(DIMENSIONS)-1:0] q_addr,
  input  logic [FEAT_WIDTH-1:0]         q_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [FEAT_WIDTH-1:0]         in_data,
  output logic                          out_valid,
  output logic [VAL_WIDTH-1:0]          out_value,
  output logic                          done
);

  localparam int AW    = $clog2(DIMENSIONS);
  localparam int SQ_W  = 2 * FEAT_WIDTH;
  localparam int ACC_W = SQ_W + AW;
  localparam int EXT_W = (ACC_W > VAL_WIDTH) ? ACC_W : VAL_WIDTH + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [AW-1:0]         dimCnt_q, dimCnt_d;
  logic [31:0]           vecCnt_q, vecCnt_d;
  logic [31:0]           numVec_q, numVec_d;
  logic [FEAT_WIDTH-1:0] query_q [DIMENSIONS];

  logic                  s1Valid_q, s1First_q, s1Last_q;
  logic [FEAT_WIDTH-1:0] s1Diff_q;
  logic                  s2Valid_q, s2First_q, s2Last_q;
  logic [SQ_W-1:0]       s2Sq_q;
  logic [ACC_W-1:0]      acc_q;
  logic                  outValid_q;
  logic [VAL_WIDTH-1:0]  outValue_q;

  logic                  busy;
  logic                  accept;
  logic                  lastDim;
  logic                  lastFeature;
  logic [FEAT_WIDTH-1:0] queryFeat;
  logic [FEAT_WIDTH-1:0] absDiff;
  logic [SQ_W-1:0]       square;
  logic [ACC_W-1:0]      accSum;
  logic [EXT_W-1:0]      accExt;
  logic                  overflow;
  logic [VAL_WIDTH-1:0]  clamped;

  assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign accept      = in_valid && (state_q == ST_RUN);
  assign lastDim     = (dimCnt_q == AW'(DIMENSIONS - 1));
  assign lastFeature = accept && lastDim && (vecCnt_q == numVec_q - 32'd1);

  assign in_ready  = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign out_valid = outValid_q;
  assign out_value = outValue_q;

  // Query registers deliberately have no reset so a loaded query survives a reset.
  always_ff @(posedge clk) begin
    if (q_wr_en && !busy && (int'(q_addr) < DIMENSIONS)) begin
      query_q[q_addr] <= q_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    dimCnt_d = dimCnt_q;
    vecCnt_d = vecCnt_q;
    numVec_d = numVec_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          numVec_d = num_vectors;
          dimCnt_d = '0;
          vecCnt_d = '0;
          state_d  = (num_vectors == 32'd0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (lastDim) begin
            dimCnt_d = '0;
            vecCnt_d = vecCnt_q + 32'd1;
          end else begin
            dimCnt_d = dimCnt_q + AW'(1);
          end
          if (lastFeature) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!s1Valid_q && !s2Valid_q) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      dimCnt_q <= '0;
      vecCnt_q <= '0;
      numVec_q <= '0;
    end else begin
      state_q  <= state_d;
      dimCnt_q <= dimCnt_d;
      vecCnt_q <= vecCnt_d;
      numVec_q <= numVec_d;
    end
  end

  assign queryFeat = query_q[dimCnt_q];
  assign absDiff   = (in_data >= queryFeat) ? (in_data - queryFeat) : (queryFeat - in_data);
  assign square    = SQ_W'(s1Diff_q) * SQ_W'(s1Diff_q);
  assign accSum    = s2First_q ? ACC_W'(s2Sq_q) : (acc_q + ACC_W'(s2Sq_q));
  assign accExt    = EXT_W'(accSum);
  assign overflow  = |(accExt >> VAL_WIDTH);
  assign clamped   = overflow ? '1 : accExt[VAL_WIDTH-1:0];

  // Valid bits move every cycle so the final vector drains even when in_valid stops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1Valid_q  <= 1'b0;
      s1First_q  <= 1'b0;
      s1Last_q   <= 1'b0;
      s1Diff_q   <= '0;
      s2Valid_q  <= 1'b0;
      s2First_q  <= 1'b0;
      s2Last_q   <= 1'b0;
      s2Sq_q     <= '0;
      acc_q      <= '0;
      outValid_q <= 1'b0;
      outValue_q <= '0;
    end else begin
      s1Valid_q <= accept;
      if (accept) begin
        s1First_q <= (dimCnt_q == '0);
        s1Last_q  <= lastDim;
        s1Diff_q  <= absDiff;
      end
      s2Valid_q <= s1Valid_q;
      if (s1Valid_q) begin
        s2First_q <= s1First_q;
        s2Last_q  <= s1Last_q;
        s2Sq_q    <= square;
      end
      outValid_q <= s2Valid_q && s2Last_q;
      if (s2Valid_q) begin
        acc_q <= accSum;
        if (s2Last_q) begin
          outValue_q <= clamped;
        end
      end
    end
  end

endmodule
